// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Sequencer that drives an external 8-bit ALU. Single ALU ops (add, invert b,
// and, or, sra, sll, beq, bneq) take one EXEC cycle. MUL (op 8) runs an
// unsigned 8x8 shift-and-add multiply through the same ALU: eight iterations
// of MUL_ADD (acc += mcand when the multiplier LSB is set) followed by
// MUL_SHIFT (mcand <<= 1). Only the low byte of the product is kept.
// Ops 9-15 are illegal: they complete at EXEC latency with err=1.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           request strobe, accepted only in IDLE or DONE
//   op[3:0]         operation code (0-7 ALU, 8 MUL, 9-15 illegal)
//   opa, opb[7:0]   operands, captured on accept
//   alu_a, alu_b    registered ALU operands
//   alu_sel[2:0]    registered ALU op select
//   alu_f[7:0]      ALU result
//   alu_ovf         ALU signed add overflow
//   alu_take_branch ALU branch decision
//   busy            high in EXEC, MUL_ADD, MUL_SHIFT
//   done            one-cycle completion pulse (DONE state)
//   result[7:0]     registered result, held until the next completion
//   ovf, taken, err registered status flags, held with result
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_ovf,
    input  logic              alu_take_branch,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              taken,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC      = 3'd1,
        MUL_ADD   = 3'd2,
        MUL_SHIFT = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_SLL = 3'd5;

    state_t            state;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [2:0]        cnt;

    function automatic logic is_illegal(input logic [3:0] code);
        return code > OP_MUL;
    endfunction

    function automatic logic is_branch(input logic [3:0] code);
        return (code == 4'd6) || (code == 4'd7);
    endfunction

    // The ALU drive lines are registered: each transition loads the values the
    // next state must present, so they are valid for the whole state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
            taken   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    // Branch ops and illegal ops report a zero result.
                    result  <= (is_branch(op_q) || is_illegal(op_q)) ? '0 : alu_f;
                    ovf     <= (op_q == 4'd0) ? alu_ovf : 1'b0;
                    taken   <= is_branch(op_q) ? alu_take_branch : 1'b0;
                    err     <= is_illegal(op_q);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    alu_sel <= '0;
                    state   <= DONE;
                end

                MUL_ADD: begin
                    if (mplier[0]) begin
                        acc <= alu_f;
                    end
                    alu_sel <= SEL_SLL;
                    alu_a   <= mcand;
                    alu_b   <= '0;
                    state   <= MUL_SHIFT;
                end

                MUL_SHIFT: begin
                    mcand  <= alu_f;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        result  <= acc;
                        ovf     <= 1'b0;
                        taken   <= 1'b0;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        alu_a   <= '0;
                        alu_b   <= '0;
                        alu_sel <= '0;
                        state   <= DONE;
                    end else begin
                        // acc is already final for this iteration; the shifted
                        // multiplicand arrives on alu_f right now.
                        alu_sel <= SEL_ADD;
                        alu_a   <= acc;
                        alu_b   <= alu_f;
                        state   <= MUL_ADD;
                    end
                end

                default: begin
                    // IDLE and DONE: the only states that accept a request.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    alu_sel <= '0;
                    state   <= IDLE;
                    if (start) begin
                        op_q <= op;
                        busy <= 1'b1;
                        if (op == OP_MUL) begin
                            acc     <= '0;
                            mcand   <= opa;
                            mplier  <= opb;
                            cnt     <= '0;
                            alu_sel <= SEL_ADD;
                            alu_a   <= '0;
                            alu_b   <= opa;
                            state   <= MUL_ADD;
                        end else begin
                            if (!is_illegal(op)) begin
                                alu_a   <= opa;
                                alu_b   <= opb;
                                alu_sel <= op[2:0];
                            end
                            state <= EXEC;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = '0;
    logic [7:0] opa = '0;
    logic [7:0] opb = '0;
    logic [7:0] alu_a, alu_b, alu_f;
    logic [2:0] alu_sel;
    logic       alu_ovf, alu_take_branch;
    logic       busy, done, ovf, taken, err;
    logic [7:0] result;

    int tests = 0;
    int fails = 0;

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_f(alu_f),
        .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch), .busy(busy),
        .done(done), .result(result), .ovf(ovf), .taken(taken), .err(err)
    );

    always #5 clk = ~clk;

    // Reference ALU: single-bit shifts, b ignored for sra/sll.
    always_comb begin
        alu_f = '0;
        alu_ovf = 1'b0;
        alu_take_branch = 1'b0;
        case (alu_sel)
            3'd0: begin
                alu_f = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            3'd1: alu_f = ~alu_b;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = {alu_a[7], alu_a[7:1]};
            3'd5: alu_f = {alu_a[6:0], 1'b0};
            3'd6: alu_take_branch = (alu_a == alu_b);
            default: alu_take_branch = (alu_a != alu_b);
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
        logic       tk;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request for exactly one rising edge (edge E); returns at the
    // falling edge after E with start low again.
    task automatic launch(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        op = o;
        opa = a;
        opb = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done, bounded; counts busy cycles on the way.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, bcnt;
        logic [2:0] exp_sel;
        exp_sel = (v.op < 4'd8) ? v.op[2:0] : 3'd0;
        launch(v.op, v.a, v.b);
        check($sformatf("v%0d_sel", idx), alu_sel, exp_sel);
        wait_done(lat, bcnt);
        check($sformatf("v%0d_lat", idx), lat, v.lat);
        check($sformatf("v%0d_busy", idx), bcnt, v.lat);
        check($sformatf("v%0d_res", idx), result, v.res);
        check($sformatf("v%0d_ovf", idx), ovf, v.ovf);
        check($sformatf("v%0d_taken", idx), taken, v.tk);
        check($sformatf("v%0d_err", idx), err, v.err);
    endtask

    initial begin
        int lat, bcnt, saw_done;

        vecs[0]  = '{4'd0,  8'd100, 8'd50,  8'h96, 1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'd1,  8'h00,  8'h0F,  8'hF0, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{4'd0,  8'hFF,  8'h01,  8'h00, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'd0,  8'h7F,  8'h01,  8'h80, 1'b1, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'd2,  8'hF0,  8'h3C,  8'h30, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'd3,  8'hF0,  8'h0F,  8'hFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'd4,  8'h80,  8'h03,  8'hC0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'd5,  8'h81,  8'h00,  8'h02, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'd6,  8'd5,   8'd5,   8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[9]  = '{4'd7,  8'd5,   8'd5,   8'h00, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{4'd7,  8'd5,   8'd6,   8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{4'd8,  8'd13,  8'd11,  8'h8F, 1'b0, 1'b0, 1'b0, 16};
        vecs[12] = '{4'd8,  8'd20,  8'd20,  8'h90, 1'b0, 1'b0, 1'b0, 16};
        vecs[13] = '{4'd8,  8'hFF,  8'hFF,  8'h01, 1'b0, 1'b0, 1'b0, 16};
        vecs[14] = '{4'd12, 8'h55,  8'hAA,  8'h00, 1'b0, 1'b0, 1'b1, 1};
        vecs[15] = '{4'd15, 8'h01,  8'h01,  8'h00, 1'b0, 1'b0, 1'b1, 1};

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        check("reset_outs", {busy, done, result, ovf, taken, err, alu_a, alu_b, alu_sel}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // Illegal op keeps the ALU select at zero for the whole operation.
        launch(4'd12, 8'hFF, 8'hFF);
        check("ill_sel_exec", {alu_sel, alu_a, alu_b}, '0);
        check("ill_busy", busy, 1'b1);
        wait_done(lat, bcnt);
        check("ill_sel_done", alu_sel, 3'd0);
        check("ill_err", err, 1'b1);

        // Start pulsed during MUL cycle 4 is dropped, not queued.
        launch(4'd8, 8'd13, 8'd11);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op = 4'd0;
        opa = 8'd1;
        opb = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check("ign_lat", lat + 4, 16);
        check("ign_res", result, 8'h8F);
        @(negedge clk);
        check("ign_no_queue", {busy, done}, 2'b00);

        // Back-to-back: start held high through DONE.
        launch(4'd3, 8'hF0, 8'h0F);
        start = 1'b1;
        wait_done(lat, bcnt);
        check("b2b_first_res", result, 8'hFF);
        op = 4'd2;
        opa = 8'hF0;
        opb = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle", {busy, done}, 2'b10);
        wait_done(lat, bcnt);
        check("b2b_lat", lat, 1);
        check("b2b_res", result, 8'h30);

        // Asynchronous reset during MUL cycle 5.
        launch(4'd8, 8'd20, 8'd20);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {busy, done, result, ovf, taken, err, alu_a, alu_b, alu_sel}, '0);
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("rst_no_done", saw_done, 0);
        launch(4'd2, 8'hF0, 8'h3C);
        wait_done(lat, bcnt);
        check("post_rst_lat", lat, 1);
        check("post_rst_res", result, 8'h30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request strobe, sampled on clk rising edge.
REQ-005 op  input  4  0-7 = ALU op codes (add, invert b, and, or, sra, sll, beq, bneq); 8 = MUL (unsigned 8x8, low byte); 9-15 illegal.
REQ-006 opa  input  8  operand A, captured on accept.
REQ-007 opb  input  8  operand B, captured on accept.
REQ-008 alu_a  output  8  ALU operand A.
REQ-009 alu_b  output  8  ALU operand B.
REQ-010 alu_sel  output  3  ALU op select.
REQ-011 alu_f  input  8  ALU result.
REQ-012 alu_ovf  input  1  ALU signed add overflow.
REQ-013 alu_take_branch  input  1  ALU branch decision.
REQ-014 busy  output  1  high in EXEC, MUL_ADD and MUL_SHIFT states.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 result  output  8  registered result; held until the next completion.
REQ-017 ovf  output  1  registered overflow; alu_ovf for op 0, otherwise 0.
REQ-018 taken  output  1  registered branch flag; alu_take_branch for ops 6/7, otherwise 0.
REQ-019 err  output  1  registered illegal-op flag.

Function
REQ-020 SHALL implement the FSM states IDLE, EXEC, MUL_ADD, MUL_SHIFT and DONE.
REQ-021 start SHALL be accepted only in IDLE or DONE; start in any other state SHALL be ignored, with no queuing.
REQ-022 On accept at edge E, the block SHALL latch opa, opb and op; op 0-7 or 9-15 -> EXEC; op 8 -> MUL_ADD with acc=0, mcand=opa, mplier=opb, cnt=0.
REQ-023 EXEC SHALL drive alu_a=opa, alu_b=opb, alu_sel=op[2:0], or all zero for an illegal op; at edge E+1 it SHALL latch result/ovf/taken/err and go to DONE.
REQ-024 MUL_ADD SHALL drive alu_sel=0, alu_a=acc, alu_b=mcand; on exit, acc SHALL load alu_f if mplier[0]=1, else hold; then go to MUL_SHIFT.
REQ-025 MUL_SHIFT SHALL drive alu_sel=5, alu_a=mcand, alu_b=0; on exit: mcand<=alu_f, mplier<=mplier>>1 (logical, internal), cnt<=cnt+1.
REQ-026 MUL_SHIFT SHALL go to DONE when cnt=7, otherwise to MUL_ADD.
REQ-027 On MUL completion, result SHALL equal acc (product mod 256), with ovf=0, taken=0, err=0.
REQ-028 Latency: done SHALL be high in the cycle after edge E+1 for non-MUL ops, and after edge E+16 for MUL.
REQ-029 done SHALL be high only in DONE; DONE SHALL go to IDLE, or to EXEC/MUL_ADD if start is sampled high there (back-to-back).
REQ-030 In IDLE and DONE, alu_a, alu_b and alu_sel SHALL be 0.
REQ-031 Ops 6/7 SHALL produce result=0; ops 1-7 and illegal ops SHALL produce ovf=0.
REQ-032 For an illegal op, the block SHALL produce result=0, err=1 and done at the same latency as EXEC.
REQ-033 Arithmetic SHALL be 8-bit and wrap modulo 256; no bits SHALL be kept beyond 8.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and clear all registers: busy=0, done=0, result=0, ovf=0, taken=0, err=0, alu_a=0, alu_b=0, alu_sel=0.
REQ-035 Reset mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-036 op=0, opa=100, opb=50 -> done one cycle after E+1; result=0x96, ovf=1, taken=0.
REQ-037 op=8, opa=13, opb=11 -> busy for 16 cycles, done after E+16; result=0x8F. op=8, opa=20, opb=20 -> result=0x90, ovf=0.
REQ-038 op=6, opa=5, opb=5 -> taken=1, result=0; then op=7 with the same operands -> taken=0.
REQ-039 start pulsed during MUL cycle 4 -> ignored, MUL result unchanged; start held high through DONE -> next op accepted back-to-back, with no IDLE cycle.
REQ-040 rst_n low during MUL cycle 5 -> all outputs 0 asynchronously, no done; after release, op=2, opa=0xF0, opb=0x3C -> result=0x30.
REQ-041 op=12 -> done one cycle after E+1; err=1, result=0, alu_sel stays 0 throughout.
